regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Sequencer and arbiter for the single write port of the 8 x DATA_W register file. After reset it clears all eight registers to zero, one per cycle. It then shares the write port between three writeback requesters (0 = ALU, 1 = load unit, 2 = move/immediate) using round-robin arbitration. Its registered `wr_addr`/`wr_en` outputs drive the register file's 3-to-8 write-address decoder (`In`/`en`), and `wr_data` drives the register data inputs.

## Interface
- `DATA_W`, default 16, register data width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `hold`  in  1  freeze arbitration; while high no grants are issued.
- `req_valid`  in  3  per-requester write request, bit i = requester i.
- `req_addr0`, `req_addr1`, `req_addr2`  in  3 each  destination register of each requester.
- `req_data0`, `req_data1`, `req_data2`  in  DATA_W each  write data of each requester.
- `req_ready`  out  3  one-hot (or zero) grant; combinational from state, pointer, `hold` and `req_valid`.
- `wr_en`  out  1  registered write enable to the decoder `en`.
- `wr_addr`  out  3  registered write address to the decoder `In`.
- `wr_data`  out  DATA_W  registered write data.
- `init_done`  out  1  high once the clear sequence has finished (state RUN).

## Operation
- **States:** CLEAR, RUN. Reset forces CLEAR, clear counter `cnt` = 0, round-robin pointer `ptr` = 0.
- **CLEAR**
  - Every edge: `wr_en` <= 1, `wr_addr` <= `cnt`, `wr_data` <= 0, `cnt` <= `cnt` + 1.
  - On the edge where `cnt` == 7, state <= RUN.
  - `req_ready` = 0 throughout. `hold` and `req_valid` are ignored.
- **RUN, grant rule**
  - If `hold` = 1 or `req_valid` = 0: `req_ready` = 0.
  - Otherwise grant the first valid requester scanning `ptr`, `ptr`+1, `ptr`+2 (mod 3).
  - `req_ready` is never asserted to a requester whose `req_valid` = 0.
- **RUN, handshake**
  - A transfer occurs on an edge where `req_valid[i]` & `req_ready[i]`.
  - On that edge: `wr_en` <= 1, `wr_addr` <= `req_addr[i]`, `wr_data` <= `req_data[i]`, `ptr` <= (i+1) mod 3.
  - A requester holds valid, addr and data stable until its transfer edge; the arbiter does not buffer.
- **RUN, no transfer:** `wr_en` <= 0; `wr_addr`/`wr_data` hold their last values; `ptr` unchanged.
- Exactly one write per cycle maximum. No address-conflict checking: same-address requests are serialized in grant order, so the last granted write wins.
- `init_done` = (state == RUN).

## Timing
- **Reset values** (asynchronous, immediate): `wr_en` 0, `wr_addr` 0, `wr_data` 0, `init_done` 0, `req_ready` 0, `ptr` 0, `cnt` 0.
- **Clear sequence:** the first edge after reset release (E1) writes r0. Edge E8 writes r7 and enters RUN.
  - `init_done` = 1 and `req_ready` may assert in the cycle after E8.
  - While r7's write is on the outputs, a grant may already be issued; the write port is pipelined.
- **Latency:** 1 cycle, from transfer edge to `wr_*` valid at the register file. The register file captures on the following edge.
- **Throughput:** one write per cycle. Back-to-back grants to different requesters are allowed.
- **Fairness:** with all three valid continuously, grants rotate 0,1,2,0,... Any requester waits at most 2 grants.
- **`hold`:** its effect on `req_ready` is combinational in the same cycle. A write already registered still appears on the outputs.
- **Reset mid-operation** (during CLEAR or RUN): outputs return to reset values immediately, any in-flight grant is dropped, and the full 8-cycle clear restarts after release.

## Test plan
- **Reset/clear:** release reset, all `req_valid` = 1.
  - Required: for the 8 cycles after E1..E8, `wr_en` = 1, `wr_addr` = 0..7, `wr_data` = 0, `req_ready` = 0.
  - Required: `init_done` = 1 after E8.
- **Single requester:** after init, `req_valid` = 3'b010, `req_addr1` = 5, `req_data1` = 16'hBEEF for one cycle.
  - Required: `req_ready` = 3'b010 that cycle.
  - Required: next cycle `wr_en` = 1, `wr_addr` = 5, `wr_data` = 16'hBEEF; the cycle after, `wr_en` = 0.
- **Round-robin:** all three valid for 6 cycles with addrs 1, 2, 3 and `ptr` = 0.
  - Required: grants 001, 010, 100, 001, 010, 100; `wr_addr` sequence 1, 2, 3, 1, 2, 3 delayed by one cycle.
- **Pointer advance:** grant requester 2 alone, then assert 3'b011.
  - Required: requester 0 is granted first (`ptr` = 0 after a grant to requester 2), then requester 1.
- **Hold:** all valid, `hold` = 1 for 3 cycles.
  - Required: `req_ready` = 0 and `wr_en` = 0 from the second cycle on; `ptr` unchanged.
  - Required: after release, the grant goes to the requester `ptr` pointed at.
- **Mid-operation reset:** assert reset during RUN while a grant is active.
  - Required: `wr_en`, `init_done` and `req_ready` drop to 0 without a clock edge.
  - Required: after release, the clear sequence r0..r7 repeats and the grant order restarts at requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register file write-port sequencer and round-robin arbiter
//
// After reset, clears all eight registers (r0..r7, one per cycle). It then
// shares the single write port between three writeback requesters
// (0 = ALU, 1 = load unit, 2 = move/immediate) in round-robin order.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   hold                suppresses all grants while high
//   req_valid[2:0]      per-requester write request
//   req_addrN/req_dataN destination register and data of requester N
//   req_ready[2:0]      one-hot grant (combinational)
//   wr_en/wr_addr/wr_data registered write to the register file decoder/data
//   init_done           high once the clear sequence has finished

module regfile_write_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        req_valid,
  input  logic [2:0]        req_addr0,
  input  logic [2:0]        req_addr1,
  input  logic [2:0]        req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [2:0]        req_ready,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt;
  logic [1:0]        ptr;
  logic [1:0]        ptr_nx;
  logic [2:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // Grant scan starts at ptr and wraps mod 3; ptr value 3 is unreachable
  // and is scanned like 0.
  always_comb begin
    state_nx  = state;
    req_ready = 3'b000;
    case (state)
      CLEAR: begin
        if (cnt == 3'd7) state_nx = RUN;
      end
      RUN: begin
        if (!hold) begin
          case (ptr)
            2'd1: begin
              if      (req_valid[1]) req_ready = 3'b010;
              else if (req_valid[2]) req_ready = 3'b100;
              else if (req_valid[0]) req_ready = 3'b001;
            end
            2'd2: begin
              if      (req_valid[2]) req_ready = 3'b100;
              else if (req_valid[0]) req_ready = 3'b001;
              else if (req_valid[1]) req_ready = 3'b010;
            end
            default: begin
              if      (req_valid[0]) req_ready = 3'b001;
              else if (req_valid[1]) req_ready = 3'b010;
              else if (req_valid[2]) req_ready = 3'b100;
            end
          endcase
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Payload mux and pointer update for the granted requester.
  always_comb begin
    sel_addr = req_addr0;
    sel_data = req_data0;
    ptr_nx   = 2'd1;
    if (req_ready[1]) begin
      sel_addr = req_addr1;
      sel_data = req_data1;
      ptr_nx   = 2'd2;
    end else if (req_ready[2]) begin
      sel_addr = req_addr2;
      sel_data = req_data2;
      ptr_nx   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 3'd0;
      ptr     <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= 3'd0;
      wr_data <= '0;
    end else if (state == CLEAR) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt;
      wr_data <= '0;
      cnt     <= cnt + 3'd1;
    end else if (|req_ready) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      ptr     <= ptr_nx;
    end else begin
      // No transfer: address/data hold their last values.
      wr_en   <= 1'b0;
    end
  end

  assign init_done = (state == RUN);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter

module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_addr0, req_addr1, req_addr2;
  logic [15:0] req_data0, req_data1, req_data2;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_addr2 (req_addr2),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_addr0 = 3'd0; req_addr1 = 3'd0; req_addr2 = 3'd0;
    req_data0 = 16'h0; req_data1 = 16'h0; req_data2 = 16'h0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", req_ready, 0);

    // Clear sequence with all requesters valid.
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("clr_wr_en", wr_en, 1);
      check("clr_wr_addr", wr_addr, k);
      check("clr_wr_data", wr_data, 0);
      check("clr_init_done", init_done, (k == 7) ? 1 : 0);
      check("clr_req_ready", req_ready, (k == 7) ? 3'b001 : 3'b000);
    end
    req_valid = 3'b000;
    @(negedge clk);
    check("idle_wr_en", wr_en, 0);
    check("idle_wr_addr", wr_addr, 7);

    // Single requester 1.
    req_valid = 3'b010; req_addr1 = 3'd5; req_data1 = 16'hBEEF; #1;
    check("single_ready", req_ready, 3'b010);
    @(negedge clk); req_valid = 3'b000;
    check("single_wr_en", wr_en, 1);
    check("single_wr_addr", wr_addr, 5);
    check("single_wr_data", wr_data, 16'hBEEF);
    @(negedge clk);
    check("single_after_en", wr_en, 0);

    // Pointer advance: grant 2 alone, then 3'b011 -> 0 then 1.
    req_valid = 3'b100; req_addr2 = 3'd3; req_data2 = 16'hA003; #1;
    check("ptr_ready2", req_ready, 3'b100);
    @(negedge clk);
    req_valid = 3'b011; req_addr0 = 3'd1; req_data0 = 16'hA001;
    req_addr1 = 3'd2; req_data1 = 16'hA002; #1;
    check("ptr_wr_addr2", wr_addr, 3);
    check("ptr_ready0", req_ready, 3'b001);
    @(negedge clk); req_valid = 3'b010; #1;
    check("ptr_wr_addr0", wr_addr, 1);
    check("ptr_ready1", req_ready, 3'b010);
    @(negedge clk);
    check("ptr_wr_addr1", wr_addr, 2);
    check("ptr_wr_data1", wr_data, 16'hA002);

    // Bring ptr back to 0 with one grant to requester 2.
    req_valid = 3'b100; #1;
    check("rr_pre_ready", req_ready, 3'b100);
    @(negedge clk);

    // Round-robin with all three valid (7 grants, leaves ptr = 1).
    req_valid = 3'b111;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("rr_ready", req_ready, 3'b001 << (i % 3));
      if (i > 0) begin
        check("rr_wr_en", wr_en, 1);
        check("rr_wr_addr", wr_addr, ((i - 1) % 3) + 1);
        check("rr_wr_data", wr_data, 16'hA000 + ((i - 1) % 3) + 1);
      end
      @(negedge clk);
    end
    check("rr_last_addr", wr_addr, 1);

    // Hold for three cycles.
    hold = 1'b1; #1;
    check("hold_ready_c1", req_ready, 0);
    check("hold_wr_en_c1", wr_en, 1);
    @(negedge clk);
    check("hold_ready_c2", req_ready, 0);
    check("hold_wr_en_c2", wr_en, 0);
    @(negedge clk);
    check("hold_ready_c3", req_ready, 0);
    check("hold_wr_en_c3", wr_en, 0);
    @(negedge clk);
    hold = 1'b0; #1;
    check("hold_release_ready", req_ready, 3'b010);
    @(negedge clk); #1;
    check("pre_rst_wr_en", wr_en, 1);
    check("pre_rst_wr_addr", wr_addr, 2);
    check("pre_rst_ready", req_ready, 3'b100);

    // Mid-operation asynchronous reset.
    reset = 1'b1; #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("reclr_wr_en", wr_en, 1);
      check("reclr_wr_addr", wr_addr, k);
      check("reclr_init_done", init_done, (k == 7) ? 1 : 0);
      check("reclr_req_ready", req_ready, (k == 7) ? 3'b001 : 3'b000);
    end
    @(negedge clk);
    check("reclr_first_grant_addr", wr_addr, 1);
    check("reclr_second_ready", req_ready, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
